// File: rtl/fft_stage_sched.sv
// Frame-level sequencer for the iterative radix-2 FFT datapath.
// After s_p reports a full frame, the sequencer walks it through every
// butterfly stage pass. It drives the mux select, the twiddle index and the
// result demux. It leaves bubbles so reg1 feedback can settle between
// passes, then hands the finished frame to p_s.
module fft_stage_sched #(
  parameter int N_STAGES = 4,
  parameter int GROUPS   = 4,
  parameter int BF_LAT   = 1,
  parameter int ROT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_p_flag_in,
  input  logic             ps_ready,
  output logic             mux_flag,
  output logic [ROT_W-1:0] rotation,
  output logic             demux_flag,
  output logic             p_s_flag,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;

  localparam logic [SW-1:0] STG_LAST = SW'(N_STAGES - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);
  localparam logic [LW-1:0] GAP_LAST = LW'(BF_LAT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_HANDOFF = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [SW-1:0] stg, stg_nxt;
  logic [GW-1:0] grp, grp_nxt;
  logic [LW-1:0] gap, gap_nxt;
  logic          ovr_st;
  logic          fire;
  logic          ovr_set;
  logic [31:0]   rot_wide;
  logic [BF_LAT-1:0] dmx_vld_p;

  // The handoff completes only when p_s is ready while we sit in HANDOFF.
  // A new frame that shows up in that same cycle is accepted, not dropped.
  assign fire    = (state == S_HANDOFF) && ps_ready;
  assign ovr_set = s_p_flag_in && (state != S_IDLE) && !fire;

  // Twiddle index: the beat index shifted by the stage number, wrapped to ROT_W bits.
  always_comb begin
    rot_wide = 32'(grp) << stg;
  end

  // Next-state and counter logic for the stage-pass sequence.
  always_comb begin
    state_nxt = state;
    stg_nxt   = stg;
    grp_nxt   = grp;
    gap_nxt   = gap;
    case (state)
      S_IDLE: begin
        if (s_p_flag_in) begin
          state_nxt = S_ISSUE;
          stg_nxt   = '0;
          grp_nxt   = '0;
        end
      end
      S_ISSUE: begin
        if (grp == GRP_LAST) begin
          grp_nxt = '0;
          if (stg != STG_LAST) begin
            state_nxt = S_GAP;
            stg_nxt   = stg + SW'(1);
          end else begin
            state_nxt = S_DRAIN;
            stg_nxt   = '0;
          end
        end else begin
          grp_nxt = grp + GW'(1);
        end
      end
      S_GAP: begin
        if (gap == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = S_ISSUE;
        end else begin
          gap_nxt = gap + LW'(1);
        end
      end
      S_DRAIN: begin
        if (gap == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = S_HANDOFF;
        end else begin
          gap_nxt = gap + LW'(1);
        end
      end
      S_HANDOFF: begin
        if (ps_ready) begin
          if (s_p_flag_in) begin
            state_nxt = S_ISSUE;
            stg_nxt   = '0;
            grp_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        stg_nxt   = '0;
        grp_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  // FSM state, counters and the sticky overrun record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      stg    <= '0;
      grp    <= '0;
      gap    <= '0;
      ovr_st <= 1'b0;
    end else begin
      state <= state_nxt;
      stg   <= stg_nxt;
      grp   <= grp_nxt;
      gap   <= gap_nxt;
      if (ovr_set) begin
        ovr_st <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the current state. The last-stage issue
  // flag runs down a BF_LAT-deep line so demux_flag lines up with clac_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_flag   <= 1'b0;
      rotation   <= '0;
      demux_flag <= 1'b0;
      p_s_flag   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dmx_vld_p  <= '0;
    end else begin
      mux_flag     <= ((state == S_ISSUE) && (stg != '0)) || (state == S_GAP);
      rotation     <= (state == S_ISSUE) ? rot_wide[ROT_W-1:0] : '0;
      p_s_flag     <= fire;
      frame_done   <= fire;
      busy         <= (state != S_IDLE);
      overrun      <= ovr_st;
      dmx_vld_p[0] <= (state == S_ISSUE) && (stg == STG_LAST);
      for (int i = 1; i < BF_LAT; i++) begin
        dmx_vld_p[i] <= dmx_vld_p[i-1];
      end
      demux_flag   <= dmx_vld_p[BF_LAT-1];
    end
  end

endmodule

// File: tb/tb_fft_stage_sched.sv
// Self-checking bench for fft_stage_sched with default parameters.
// Expected output vectors are queued per cycle when a scenario's stimulus is
// planned, then popped and compared after each clock edge.
module tb_fft_stage_sched;

  localparam int G       = 4;
  localparam int N       = 4;
  localparam int L       = 1;
  localparam int PER     = G + L + 1;
  localparam int ISS_END = N * G + (N - 1) * (L + 1);
  localparam int DEM_ST  = 1 + (N - 1) * PER + L;
  localparam int LAT     = ISS_END + (L + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_p_flag_in = 1'b0;
  logic       ps_ready = 1'b0;
  logic       mux_flag;
  logic [2:0] rotation;
  logic       demux_flag;
  logic       p_s_flag;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] ev;
  logic [8:0] av;
  int rot_tab [16] = '{0, 1, 2, 3, 0, 2, 4, 6, 0, 4, 0, 4, 0, 0, 0, 0};

  fft_stage_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_p_flag_in(s_p_flag_in),
    .ps_ready   (ps_ready),
    .mux_flag   (mux_flag),
    .rotation   (rotation),
    .demux_flag (demux_flag),
    .p_s_flag   (p_s_flag),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Packed view: {busy, mux, rotation[2:0], demux, p_s_flag, frame_done, overrun}
  function automatic logic [8:0] out_vec();
    return {busy, mux_flag, rotation, demux_flag, p_s_flag, frame_done, overrun};
  endfunction

  // Expected outputs t cycles after a frame pulse sampled at t=0, with the
  // handoff firing at cycle th.
  function automatic logic [8:0] frame_exp(int t, int th);
    logic b, m, d, p;
    logic [2:0] r;
    int s, o;
    b = 1'b0; m = 1'b0; d = 1'b0; p = 1'b0; r = 3'd0;
    if (t >= 1 && t <= th) b = 1'b1;
    if (t >= 1 && t <= ISS_END) begin
      s = (t - 1) / PER;
      o = (t - 1) % PER;
      if (o < G) begin
        m = (s != 0);
        r = 3'(rot_tab[s * G + o]);
      end else begin
        m = 1'b1;
      end
    end
    if (t >= DEM_ST && t < DEM_ST + G) d = 1'b1;
    if (t == th) p = 1'b1;
    return {b, m, r, d, p, p, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    s_p_flag_in = 1'b0;
    ps_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(9'd0);
    ev = exp_q.pop_front();
    av = out_vec();
    vectors++;
    if (av !== ev) begin
      miscompares++;
      $display("FAIL reset_hold act=%b exp=%b", av, ev);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 50; t++) exp_q.push_back(9'd0);
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL reset_idle t=%0d act=%b exp=%b", t, av, ev);
      end
    end
  endtask

  task automatic test_single_frame();
    for (int t = 0; t <= 30; t++) exp_q.push_back(frame_exp(t, LAT));
    for (int t = 0; t <= 30; t++) begin
      s_p_flag_in = (t == 0);
      ps_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL single t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int t = 0; t <= 45; t++) exp_q.push_back(frame_exp(t, 40));
    for (int t = 0; t <= 45; t++) begin
      s_p_flag_in = (t == 0);
      // ready wiggles early on (must be ignored), then low until cycle 40
      ps_ready = (t < 24) ? 1'(t % 2) : (t >= 40);
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL backpressure t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
    ps_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t <= 55; t++) exp_q.push_back(frame_exp(t, LAT) | frame_exp(t - LAT, LAT));
    for (int t = 0; t <= 55; t++) begin
      s_p_flag_in = (t == 0) || (t == LAT);
      ps_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL back_to_back t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
  endtask

  task automatic test_overrun();
    for (int t = 0; t <= 40; t++) exp_q.push_back(frame_exp(t, LAT) | {8'd0, 1'(t >= 11)});
    for (int t = 0; t <= 40; t++) begin
      s_p_flag_in = (t == 0) || (t == 10);
      ps_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL overrun t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
  endtask

  task automatic test_reset_midframe();
    for (int t = 0; t <= 14; t++) exp_q.push_back(frame_exp(t, LAT) | 9'd1);
    for (int t = 0; t <= 14; t++) begin
      s_p_flag_in = (t == 0);
      ps_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL midframe_pre t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(9'd0);
    ev = exp_q.pop_front();
    av = out_vec();
    vectors++;
    if (av !== ev) begin
      miscompares++;
      $display("FAIL midframe_async act=%b exp=%b", av, ev);
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(9'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL midframe_held k=%0d act=%b exp=%b", k, av, ev);
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t <= 30; t++) exp_q.push_back(frame_exp(t, LAT));
    for (int t = 0; t <= 30; t++) begin
      s_p_flag_in = (t == 0);
      ps_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = exp_q.pop_front();
      av = out_vec();
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL midframe_restart t=%0d act=%b exp=%b", t, av, ev);
      end
    end
    s_p_flag_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
